if_id_buf: RTL and testbench

Fetch-to-decode pipeline register with a one-entry skid slot, sitting directly downstream of the PC stage and the instruction ROM. Each cycle it captures the PC and the ROM word for that PC and presents them to decode one cycle later. It absorbs a decode stall without losing the in-flight instruction, tells the PC stage to hold, and supports a flush that turns its contents into bubbles.

---
 rtl/if_id_buf_pkg.sv | 19 +
 rtl/if_id_buf_slot.sv | 47 ++++
 rtl/if_id_buf.sv | 99 +++++++++
 tb/tb_if_id_buf.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/if_id_buf_pkg.sv
// if_id_buf_pkg
//   Shared definitions for the fetch-to-decode buffer: default widths,
//   the NOP encoding used for bubbles, and the per-slot control enum.
package if_id_buf_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 32;

  // A bubble carries an all-zero instruction word.
  localparam logic [DATA_W_DEF-1:0] NOP_INST = '0;

  // Per-cycle action applied to one valid+pc+inst slot.
  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,
    SLOT_LOAD  = 2'd1,
    SLOT_CLEAR = 2'd2
  } slot_op_e;

endpackage

// File: rtl/if_id_buf_slot.sv
// if_id_slot
//   One valid+pc+inst register with hold / load / clear-to-bubble control.
//   Ports:
//     clk, rst        clock, synchronous active-low reset (clears to bubble)
//     op              SLOT_HOLD, SLOT_LOAD or SLOT_CLEAR for this edge
//     d_valid/pc/inst data written on SLOT_LOAD
//     valid/pc/inst   registered slot contents
module if_id_slot
  import if_id_buf_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  slot_op_e          op,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [DATA_W-1:0] d_inst,
  output logic              valid,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] inst
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= DATA_W'(NOP_INST);
    end else begin
      case (op)
        SLOT_LOAD: begin
          valid <= d_valid;
          pc    <= d_pc;
          inst  <= d_inst;
        end
        SLOT_CLEAR: begin
          valid <= 1'b0;
          pc    <= '0;
          inst  <= DATA_W'(NOP_INST);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/if_id_buf.sv
// if_id_buf
//   Fetch-to-decode pipeline register with a one-entry skid slot.
//   Ports:
//     clk, rst       clock, synchronous active-low reset
//     if_ce          fetch slot from PC stage is valid
//     if_pc, if_inst PC and combinational ROM word for it
//     stall_id       decode cannot take a new instruction this cycle
//     flush          turn all buffered/in-flight instructions into bubbles
//     if_hold        PC stage must not advance at the next edge (= skid full)
//     id_valid/pc/inst  instruction presented to decode
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [DATA_W-1:0] if_inst,
  input  logic              stall_id,
  input  logic              flush,
  output logic              if_hold,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst
);

  slot_op_e          main_op;
  slot_op_e          skid_op;
  logic              main_d_valid;
  logic [ADDR_W-1:0] main_d_pc;
  logic [DATA_W-1:0] main_d_inst;
  logic              skid_valid;
  logic [ADDR_W-1:0] skid_pc;
  logic [DATA_W-1:0] skid_inst;
  logic              accept;

  // While the skid is full the PC stage is frozen, so the presented slot
  // is a repeat that will be offered again; never accept it.
  assign accept  = if_ce & ~skid_valid;
  assign if_hold = skid_valid;

  always_comb begin
    main_op      = SLOT_HOLD;
    skid_op      = SLOT_HOLD;
    main_d_valid = 1'b0;
    main_d_pc    = '0;
    main_d_inst  = DATA_W'(NOP_INST);

    if (flush) begin
      main_op = SLOT_CLEAR;
      skid_op = SLOT_CLEAR;
    end else if (stall_id) begin
      if (!skid_valid && accept) begin
        skid_op = SLOT_LOAD;
      end
    end else if (skid_valid) begin
      main_op      = SLOT_LOAD;
      main_d_valid = 1'b1;
      main_d_pc    = skid_pc;
      main_d_inst  = skid_inst;
      skid_op      = SLOT_CLEAR;
    end else begin
      main_op = SLOT_LOAD;
      if (accept) begin
        main_d_valid = 1'b1;
        main_d_pc    = if_pc;
        main_d_inst  = if_inst;
      end
    end
  end

  if_id_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .op      (main_op),
    .d_valid (main_d_valid),
    .d_pc    (main_d_pc),
    .d_inst  (main_d_inst),
    .valid   (id_valid),
    .pc      (id_pc),
    .inst    (id_inst)
  );

  if_id_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .op      (skid_op),
    .d_valid (1'b1),
    .d_pc    (if_pc),
    .d_inst  (if_inst),
    .valid   (skid_valid),
    .pc      (skid_pc),
    .inst    (skid_inst)
  );

endmodule

// File: tb/tb_if_id_buf.sv
// tb_if_id_buf
//   Self-checking bench for if_id_buf: a hand-derived vector table, a PC
//   wrap sequence, and randomized stimulus compared against a queue model
//   of in-order instruction delivery.
module tb_if_id_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce;
  logic [5:0]  if_pc;
  logic [31:0] if_inst;
  logic        stall_id;
  logic        flush;
  logic        if_hold;
  logic        id_valid;
  logic [5:0]  id_pc;
  logic [31:0] id_inst;

  if_id_buf #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_ce    (if_ce),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .stall_id (stall_id),
    .flush    (flush),
    .if_hold  (if_hold),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_inst  (id_inst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [5:0]  pc;
    logic [31:0] inst;
  } ent_t;

  localparam ent_t BUBBLE = '{v: 1'b0, pc: 6'd0, inst: 32'd0};

  typedef struct {
    logic       r, ce, st, fl;
    logic       ev;
    logic [5:0] epc;
    logic       ehold;
  } vec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned nstep  = 0;

  logic [5:0]  pc;          // PC stage model
  logic [31:0] rom [64];
  ent_t        q [$];       // entries in delivery order; q[0] is what decode sees
  logic [5:0]  delivered [$];

  // Reference: instructions flow in order through at most two places.
  // Decode consumes the head when not stalled; a fetch is accepted only
  // when fewer than two are held, and after a consume the freed main
  // position takes the fetch (or a bubble) only if nothing was waiting.
  task automatic model_edge(input logic r, ce, st, fl, input ent_t f);
    logic full;
    full = (q.size() == 2);
    if (!r || fl) begin
      q.delete();
      q.push_back(BUBBLE);
    end else if (st) begin
      if (!full && ce) q.push_back(f);
    end else begin
      void'(q.pop_front());
      if (q.size() == 0) q.push_back(ce && !full ? f : BUBBLE);
    end
  endtask

  task automatic step(input logic r, ce, st, fl);
    ent_t f;
    logic adv;
    rst = r; if_ce = ce; stall_id = st; flush = fl;
    if_pc = pc; if_inst = rom[pc];
    f = '{v: 1'b1, pc: pc, inst: rom[pc]};
    #1;
    if (r && !fl && !st && id_valid) delivered.push_back(id_pc);
    adv = r && ce && !if_hold;
    model_edge(r, ce, st, fl, f);
    @(posedge clk);
    #1;
    if (!r) pc = 6'd0;
    else if (adv) pc = pc + 6'd1;
    nstep++;
    checks++;
    if ({id_valid, id_pc, id_inst, if_hold} !== {q[0].v, q[0].pc, q[0].inst, q.size() == 2}) begin
      errors++;
      $display("FAIL model step %0d: got v=%0b pc=%0d inst=%h hold=%0b, want v=%0b pc=%0d inst=%h hold=%0b",
               nstep, id_valid, id_pc, id_inst, if_hold, q[0].v, q[0].pc, q[0].inst, q.size() == 2);
    end
  endtask

  vec_t tbl [23];

  initial begin
    logic [31:0] ei;
    logic [5:0]  wrap_exp [4];

    for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + i;
    pc = 6'd0;
    q.push_back(BUBBLE);
    rst = 1'b0; if_ce = 1'b0; stall_id = 1'b0; flush = 1'b0;
    if_pc = '0; if_inst = '0;
    @(negedge clk);

    //          r     ce    st    fl    ev    epc   ehold
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd2, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd3, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd4, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'd1, 1'b1};  // PC 2 parked in skid
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'd1, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'd1, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd2, 1'b0};  // skid drains, PC 3 dropped
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd3, 1'b0};  // refetched PC 3
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd4, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'd4, 1'b1};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0};  // flush with skid full
    tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd6, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'd6, 1'b1};
    tbl[20] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0};  // reset mid-stall
    tbl[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0};
    tbl[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0};

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].r, tbl[i].ce, tbl[i].st, tbl[i].fl);
      ei = tbl[i].ev ? 32'h1000_0000 + {26'd0, tbl[i].epc} : 32'd0;
      checks++;
      if ({id_valid, id_pc, id_inst, if_hold} !== {tbl[i].ev, tbl[i].epc, ei, tbl[i].ehold}) begin
        errors++;
        $display("FAIL table[%0d]: got v=%0b pc=%0d inst=%h hold=%0b, want v=%0b pc=%0d inst=%h hold=%0b",
                 i, id_valid, id_pc, id_inst, if_hold, tbl[i].ev, tbl[i].epc, ei, tbl[i].ehold);
      end
    end

    // PC wrap with a one-cycle stall while 63 is presented.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    pc = 6'd62;
    delivered.delete();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    wrap_exp[0] = 6'd62; wrap_exp[1] = 6'd63; wrap_exp[2] = 6'd0; wrap_exp[3] = 6'd1;
    checks++;
    if (delivered.size() != 4) begin
      errors++;
      $display("FAIL wrap_count: got %0d delivered, want 4", delivered.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (delivered[i] !== wrap_exp[i]) begin
          errors++;
          $display("FAIL wrap_seq[%0d]: got pc=%0d, want pc=%0d", i, delivered[i], wrap_exp[i]);
        end
      end
    end

    // Randomized traffic with a randomized ROM.
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 59) != 0,
           $urandom_range(0, 99) < 85,
           $urandom_range(0, 99) < 40,
           $urandom_range(0, 29) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
